// File: rtl/stage_id_pkg.sv
// Shared types, opcodes and immediate helpers for the
// multithreaded decode stage.
package stage_id_pkg;

    localparam int N_THREADS = 4;
    localparam int N_REGS = 32;
    localparam int TID_W =
        (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

    typedef logic [TID_W-1:0] threadid_t;
    typedef logic [31:0] word_t;
    typedef logic [31:0] vptr_t;
    typedef logic [4:0] regid_t;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_MUL,
        ALU_PASS
    } alu_op_t;

    typedef enum logic [1:0] {
        EXC_NONE,
        EXC_ITLB_MISS,
        EXC_ILLEGAL
    } exc_cause_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;
    localparam logic [6:0] F7_MUL = 7'b0000001;

    typedef struct packed {
        logic       valid;
        vptr_t      pc;
        threadid_t  thread;
        alu_op_t    alu_op;
        word_t      rs1_data;
        word_t      rs2_data;
        word_t      imm;
        logic       use_imm;
        regid_t     rd;
        logic       reg_we;
        logic       mem_ren;
        logic       mem_wen;
        logic       mem_byte;
        logic       branch;
        logic       jump;
        logic       exception;
        exc_cause_t exc_cause;
    } decode_t;

    function automatic word_t imm_i(word_t i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic word_t imm_s(word_t i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic word_t imm_b(word_t i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic word_t imm_j(word_t i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/stage_id_if.sv
// IF/ID inputs, writeback/flush controls and the registered
// ID/EX bundle of the decode stage.
interface stage_id_if;
    import stage_id_pkg::*;

    logic       if_itlb_miss;
    logic       if_icache_miss;
    vptr_t      if_pc;
    word_t      if_instruction;
    threadid_t  if_thread;
    logic       wb_en;
    logic       wb_we;
    threadid_t  wb_thread;
    regid_t     wb_rd;
    word_t      wb_data;
    logic       flush_en;
    threadid_t  flush_thread;
    logic       replay_en;
    threadid_t  replay_thread;
    vptr_t      replay_pc;
    logic       ex_valid;
    vptr_t      ex_pc;
    threadid_t  ex_thread;
    alu_op_t    ex_alu_op;
    word_t      ex_rs1_data;
    word_t      ex_rs2_data;
    word_t      ex_imm;
    logic       ex_use_imm;
    regid_t     ex_rd;
    logic       ex_reg_we;
    logic       ex_mem_ren;
    logic       ex_mem_wen;
    logic       ex_mem_byte;
    logic       ex_branch;
    logic       ex_jump;
    logic       ex_exception;
    exc_cause_t ex_exc_cause;

    modport master (
        output if_itlb_miss, if_icache_miss, if_pc,
               if_instruction, if_thread,
               wb_en, wb_we, wb_thread, wb_rd, wb_data,
               flush_en, flush_thread,
        input  replay_en, replay_thread, replay_pc,
               ex_valid, ex_pc, ex_thread, ex_alu_op,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_use_imm,
               ex_rd, ex_reg_we, ex_mem_ren, ex_mem_wen,
               ex_mem_byte, ex_branch, ex_jump,
               ex_exception, ex_exc_cause
    );

    modport slave (
        input  if_itlb_miss, if_icache_miss, if_pc,
               if_instruction, if_thread,
               wb_en, wb_we, wb_thread, wb_rd, wb_data,
               flush_en, flush_thread,
        output replay_en, replay_thread, replay_pc,
               ex_valid, ex_pc, ex_thread, ex_alu_op,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_use_imm,
               ex_rd, ex_reg_we, ex_mem_ren, ex_mem_wen,
               ex_mem_byte, ex_branch, ex_jump,
               ex_exception, ex_exc_cause
    );

endinterface

// File: rtl/stage_id_regfile_mt.sv
// Per-thread register file: one write port, two async read
// ports with write-to-read bypass; x0 reads zero.
module regfile_mt
    import stage_id_pkg::*;
#(
    parameter int n_threads = N_THREADS,
    parameter int n_regs = N_REGS
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  threadid_t w_thread,
    input  regid_t    w_rd,
    input  word_t     w_data,
    input  threadid_t r_thread,
    input  regid_t    r_rs1,
    input  regid_t    r_rs2,
    output word_t     r_data1,
    output word_t     r_data2
);

    word_t mem [n_threads][n_regs];
    logic  wr;

    assign wr = we && (w_rd != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < n_threads; t++) begin
                for (int r = 0; r < n_regs; r++) begin
                    mem[t][r] <= '0;
                end
            end
        end else if (wr) begin
            mem[w_thread][w_rd] <= w_data;
        end
    end

    always_comb begin
        r_data1 = mem[r_thread][r_rs1];
        if (r_rs1 == '0) begin
            r_data1 = '0;
        end else if (wr && w_thread == r_thread
                     && w_rd == r_rs1) begin
            r_data1 = w_data;
        end
    end

    always_comb begin
        r_data2 = mem[r_thread][r_rs2];
        if (r_rs2 == '0) begin
            r_data2 = '0;
        end else if (wr && w_thread == r_thread
                     && w_rd == r_rs2) begin
            r_data2 = w_data;
        end
    end

endmodule

// File: rtl/stage_id.sv
// Decode stage: field decode, per-thread register read,
// scoreboard hazard check and registered ID/EX bundle.
module stage_id
    import stage_id_pkg::*;
#(
    parameter int n_threads = N_THREADS,
    parameter int n_regs = N_REGS
) (
    input logic       clk,
    input logic       rst,
    stage_id_if.slave bus
);

    word_t      ins;
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    regid_t     rs1;
    regid_t     rs2;
    regid_t     rd;
    word_t      rdata1;
    word_t      rdata2;

    assign ins = bus.if_instruction;
    assign opc = ins[6:0];
    assign rd  = ins[11:7];
    assign f3  = ins[14:12];
    assign rs1 = ins[19:15];
    assign rs2 = ins[24:20];
    assign f7  = ins[31:25];

    regfile_mt #(
        .n_threads(n_threads),
        .n_regs(n_regs)
    ) u_rf (
        .clk(clk),
        .rst(rst),
        .we(bus.wb_en && bus.wb_we),
        .w_thread(bus.wb_thread),
        .w_rd(bus.wb_rd),
        .w_data(bus.wb_data),
        .r_thread(bus.if_thread),
        .r_rs1(rs1),
        .r_rs2(rs2),
        .r_data1(rdata1),
        .r_data2(rdata2)
    );

    decode_t dec;
    decode_t exc_b;
    logic    use_rs1;
    logic    use_rs2;
    logic    use_rd;
    logic    illegal;

    always_comb begin
        dec = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd = 1'b0;
        illegal = 1'b0;
        dec.valid = 1'b1;
        dec.pc = bus.if_pc;
        dec.thread = bus.if_thread;
        dec.alu_op = ALU_ADD;
        unique case (1'b1)
            opc == OP_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd = 1'b1;
                dec.reg_we = 1'b1;
                illegal = (f3 != 3'b000);
                unique case (f7)
                    F7_ADD: dec.alu_op = ALU_ADD;
                    F7_SUB: dec.alu_op = ALU_SUB;
                    F7_MUL: dec.alu_op = ALU_MUL;
                    default: illegal = 1'b1;
                endcase
            end
            opc == OP_IMM: begin
                use_rs1 = 1'b1;
                use_rd = 1'b1;
                dec.reg_we = 1'b1;
                dec.use_imm = 1'b1;
                dec.imm = imm_i(ins);
                illegal = (f3 != 3'b000);
            end
            opc == OP_LOAD: begin
                use_rs1 = 1'b1;
                use_rd = 1'b1;
                dec.reg_we = 1'b1;
                dec.mem_ren = 1'b1;
                dec.mem_byte = (f3 == 3'b000);
                dec.use_imm = 1'b1;
                dec.imm = imm_i(ins);
                illegal = (f3 != 3'b000) && (f3 != 3'b010);
            end
            opc == OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec.mem_wen = 1'b1;
                dec.mem_byte = (f3 == 3'b000);
                dec.use_imm = 1'b1;
                dec.imm = imm_s(ins);
                illegal = (f3 != 3'b000) && (f3 != 3'b010);
            end
            opc == OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
                dec.imm = imm_b(ins);
                illegal = (f3 != 3'b000);
            end
            opc == OP_JAL: begin
                use_rd = 1'b1;
                dec.reg_we = 1'b1;
                dec.jump = 1'b1;
                dec.alu_op = ALU_PASS;
                dec.imm = imm_j(ins);
            end
            default: illegal = 1'b1;
        endcase
        dec.rd = use_rd ? rd : '0;
        dec.rs1_data = use_rs1 ? rdata1 : '0;
        dec.rs2_data = use_rs2 ? rdata2 : '0;
    end

    always_comb begin
        exc_b = '0;
        exc_b.valid = 1'b1;
        exc_b.pc = bus.if_pc;
        exc_b.thread = bus.if_thread;
        exc_b.exception = 1'b1;
        if (bus.if_itlb_miss) begin
            exc_b.exc_cause = EXC_ITLB_MISS;
        end else begin
            exc_b.exc_cause = EXC_ILLEGAL;
        end
    end

    logic [n_regs-1:0] sb [n_threads];
    logic              wb_same;
    logic              busy1;
    logic              busy2;
    logic              busyd;
    logic              hazard;
    logic              flush_hit;

    // A writeback releasing the register this cycle counts as free.
    assign wb_same = bus.wb_en && (bus.wb_thread == bus.if_thread);
    assign busy1 = use_rs1 && (rs1 != '0)
                   && sb[bus.if_thread][rs1]
                   && !(wb_same && bus.wb_rd == rs1);
    assign busy2 = use_rs2 && (rs2 != '0)
                   && sb[bus.if_thread][rs2]
                   && !(wb_same && bus.wb_rd == rs2);
    assign busyd = use_rd && (rd != '0)
                   && sb[bus.if_thread][rd]
                   && !(wb_same && bus.wb_rd == rd);
    assign hazard = busy1 || busy2 || busyd;
    assign flush_hit = bus.flush_en
                       && (bus.flush_thread == bus.if_thread);

    decode_t   ex_q;
    logic      rep_en_q;
    threadid_t rep_thr_q;
    vptr_t     rep_pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
            rep_en_q <= 1'b0;
            rep_thr_q <= '0;
            rep_pc_q <= '0;
            for (int t = 0; t < n_threads; t++) begin
                sb[t] <= '0;
            end
        end else begin
            ex_q <= '0;
            rep_en_q <= 1'b0;
            rep_thr_q <= '0;
            rep_pc_q <= '0;
            if (bus.wb_en) begin
                sb[bus.wb_thread][bus.wb_rd] <= 1'b0;
            end
            if (bus.if_icache_miss || flush_hit) begin
                ex_q <= '0;
            end else if (bus.if_itlb_miss || illegal) begin
                ex_q <= exc_b;
            end else if (hazard) begin
                rep_en_q <= 1'b1;
                rep_thr_q <= bus.if_thread;
                rep_pc_q <= bus.if_pc;
            end else begin
                ex_q <= dec;
                // Set after the clear so a same-edge set wins.
                if (dec.reg_we && rd != '0) begin
                    sb[bus.if_thread][rd] <= 1'b1;
                end
            end
        end
    end

    assign bus.replay_en     = rep_en_q;
    assign bus.replay_thread = rep_thr_q;
    assign bus.replay_pc     = rep_pc_q;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_thread     = ex_q.thread;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_rs1_data   = ex_q.rs1_data;
    assign bus.ex_rs2_data   = ex_q.rs2_data;
    assign bus.ex_imm        = ex_q.imm;
    assign bus.ex_use_imm    = ex_q.use_imm;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_reg_we     = ex_q.reg_we;
    assign bus.ex_mem_ren    = ex_q.mem_ren;
    assign bus.ex_mem_wen    = ex_q.mem_wen;
    assign bus.ex_mem_byte   = ex_q.mem_byte;
    assign bus.ex_branch     = ex_q.branch;
    assign bus.ex_jump       = ex_q.jump;
    assign bus.ex_exception  = ex_q.exception;
    assign bus.ex_exc_cause  = ex_q.exc_cause;

endmodule

// File: tb/tb_stage_id.sv
// Directed-vector bench for stage_id with a queue-based
// scoreboard and a negedge monitor.
module tb_stage_id;
    import stage_id_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stage_id_if bus();

    stage_id dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int         due;
        string      nm;
        logic       valid;
        vptr_t      pc;
        threadid_t  thr;
        alu_op_t    alu;
        word_t      rs1;
        word_t      rs2;
        word_t      imm;
        logic       use_imm;
        regid_t     rd;
        logic       reg_we;
        logic       ren;
        logic       wen;
        logic       mbyte;
        logic       br;
        logic       jmp;
        logic       exc;
        exc_cause_t cause;
        logic       rep;
        threadid_t  rthr;
        vptr_t      rpc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp(exp_t e);
        chk({e.nm, ".valid"}, 32'(bus.ex_valid), 32'(e.valid));
        chk({e.nm, ".pc"}, bus.ex_pc, e.pc);
        chk({e.nm, ".thread"}, 32'(bus.ex_thread), 32'(e.thr));
        chk({e.nm, ".alu"}, 32'(bus.ex_alu_op), 32'(e.alu));
        chk({e.nm, ".rs1"}, bus.ex_rs1_data, e.rs1);
        chk({e.nm, ".rs2"}, bus.ex_rs2_data, e.rs2);
        chk({e.nm, ".imm"}, bus.ex_imm, e.imm);
        chk({e.nm, ".use_imm"}, 32'(bus.ex_use_imm),
            32'(e.use_imm));
        chk({e.nm, ".rd"}, 32'(bus.ex_rd), 32'(e.rd));
        chk({e.nm, ".reg_we"}, 32'(bus.ex_reg_we), 32'(e.reg_we));
        chk({e.nm, ".ren"}, 32'(bus.ex_mem_ren), 32'(e.ren));
        chk({e.nm, ".wen"}, 32'(bus.ex_mem_wen), 32'(e.wen));
        chk({e.nm, ".byte"}, 32'(bus.ex_mem_byte), 32'(e.mbyte));
        chk({e.nm, ".branch"}, 32'(bus.ex_branch), 32'(e.br));
        chk({e.nm, ".jump"}, 32'(bus.ex_jump), 32'(e.jmp));
        chk({e.nm, ".exc"}, 32'(bus.ex_exception), 32'(e.exc));
        chk({e.nm, ".cause"}, 32'(bus.ex_exc_cause), 32'(e.cause));
        chk({e.nm, ".replay"}, 32'(bus.replay_en), 32'(e.rep));
        chk({e.nm, ".rthread"}, 32'(bus.replay_thread),
            32'(e.rthr));
        chk({e.nm, ".rpc"}, bus.replay_pc, e.rpc);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
            cmp(q.pop_front());
        end
    end

    function automatic exp_t bub(string nm);
        exp_t e;
        e.due = 0; e.nm = nm; e.valid = 1'b0; e.pc = '0;
        e.thr = '0; e.alu = ALU_ADD; e.rs1 = '0; e.rs2 = '0;
        e.imm = '0; e.use_imm = 1'b0; e.rd = '0;
        e.reg_we = 1'b0; e.ren = 1'b0; e.wen = 1'b0;
        e.mbyte = 1'b0; e.br = 1'b0; e.jmp = 1'b0;
        e.exc = 1'b0; e.cause = EXC_NONE; e.rep = 1'b0;
        e.rthr = '0; e.rpc = '0;
        return e;
    endfunction

    function automatic exp_t rep(string nm, threadid_t t,
                                 vptr_t pc);
        exp_t e = bub(nm);
        e.rep = 1'b1; e.rthr = t; e.rpc = pc;
        return e;
    endfunction

    function automatic exp_t exc(string nm, vptr_t pc,
                                 threadid_t t, exc_cause_t c);
        exp_t e = bub(nm);
        e.valid = 1'b1; e.pc = pc; e.thr = t;
        e.exc = 1'b1; e.cause = c;
        return e;
    endfunction

    function automatic exp_t ok(string nm, vptr_t pc,
                                threadid_t t, alu_op_t a,
                                word_t d1, word_t d2, word_t imm,
                                logic ui, regid_t rd, logic we);
        exp_t e = bub(nm);
        e.valid = 1'b1; e.pc = pc; e.thr = t; e.alu = a;
        e.rs1 = d1; e.rs2 = d2; e.imm = imm; e.use_imm = ui;
        e.rd = rd; e.reg_we = we;
        return e;
    endfunction

    function automatic word_t enc_r(logic [6:0] f7, regid_t s2,
                                    regid_t s1, regid_t d);
        return {f7, s2, s1, 3'b000, d, OP_R};
    endfunction

    function automatic word_t enc_i(logic [11:0] imm, regid_t s1,
                                    logic [2:0] f3, regid_t d,
                                    logic [6:0] op);
        return {imm, s1, f3, d, op};
    endfunction

    function automatic word_t enc_s(logic [11:0] imm, regid_t s2,
                                    regid_t s1, logic [2:0] f3);
        return {imm[11:5], s2, s1, f3, imm[4:0], OP_STORE};
    endfunction

    function automatic word_t enc_b(logic [12:0] imm, regid_t s2,
                                    regid_t s1);
        return {imm[12], imm[10:5], s2, s1, 3'b000,
                imm[4:1], imm[11], OP_BRANCH};
    endfunction

    function automatic word_t enc_j(logic [20:0] imm, regid_t d);
        return {imm[20], imm[10:1], imm[11], imm[19:12], d, OP_JAL};
    endfunction

    task automatic quiet();
        bus.if_itlb_miss = 1'b0;
        bus.if_icache_miss = 1'b0;
        bus.wb_en = 1'b0;
        bus.wb_we = 1'b0;
        bus.wb_thread = '0;
        bus.wb_rd = '0;
        bus.wb_data = '0;
        bus.flush_en = 1'b0;
        bus.flush_thread = '0;
    endtask

    task automatic drive(threadid_t t, vptr_t pc, word_t ins,
                         exp_t e);
        bus.if_thread = t;
        bus.if_pc = pc;
        bus.if_instruction = ins;
        e.due = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
        quiet();
    endtask

    exp_t e;

    initial begin
        rst = 1'b1;
        quiet();
        bus.if_thread = '0;
        bus.if_pc = '0;
        bus.if_instruction = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(bus.ex_valid), 32'h0);
        chk("rst.replay", 32'(bus.replay_en), 32'h0);
        chk("rst.pc", bus.ex_pc, 32'h0);
        rst = 1'b0;

        drive(0, 32'h100, enc_i(12'hFFF, 0, 3'b000, 5, OP_IMM),
              ok("addi_x5", 32'h100, 0, ALU_ADD, 0, 0,
                 32'hFFFF_FFFF, 1, 5, 1));
        drive(0, 32'h104, enc_r(F7_ADD, 5, 5, 6),
              rep("add_x6_stall", 0, 32'h104));
        bus.wb_en = 1'b1; bus.wb_we = 1'b1; bus.wb_thread = 0;
        bus.wb_rd = 5; bus.wb_data = 32'hFFFF_FFFF;
        drive(0, 32'h104, enc_r(F7_ADD, 5, 5, 6),
              ok("add_x6_bypass", 32'h104, 0, ALU_ADD,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 6, 1));
        drive(0, 32'h108, enc_r(F7_ADD, 0, 5, 12),
              ok("add_x12_rf", 32'h108, 0, ALU_ADD,
                 32'hFFFF_FFFF, 0, 0, 0, 12, 1));
        drive(0, 32'h10C, enc_r(F7_SUB, 5, 5, 13),
              ok("sub_x13", 32'h10C, 0, ALU_SUB,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 13, 1));
        drive(0, 32'h110, enc_r(F7_MUL, 6, 12, 14),
              rep("mul_stall", 0, 32'h110));

        drive(2, 32'h200, enc_i(12'd5, 0, 3'b000, 7, OP_IMM),
              ok("t2_addi_x7", 32'h200, 2, ALU_ADD, 0, 0, 5, 1, 7, 1));
        drive(3, 32'h300, enc_r(F7_ADD, 7, 7, 8),
              ok("t3_add_x8", 32'h300, 3, ALU_ADD, 0, 0, 0, 0, 8, 1));
        drive(2, 32'h204, enc_i(12'd1, 0, 3'b000, 7, OP_IMM),
              rep("t2_waw", 2, 32'h204));

        bus.if_itlb_miss = 1'b1; bus.if_icache_miss = 1'b1;
        drive(1, 32'h3F0, enc_i(12'd1, 0, 3'b000, 10, OP_IMM),
              bub("itlb_icache"));
        bus.if_itlb_miss = 1'b1;
        drive(1, 32'h400, enc_i(12'd1, 0, 3'b000, 10, OP_IMM),
              exc("itlb", 32'h400, 1, EXC_ITLB_MISS));
        drive(1, 32'h404, enc_r(F7_ADD, 10, 10, 1),
              ok("t1_add_x1", 32'h404, 1, ALU_ADD, 0, 0, 0, 0, 1, 1));

        drive(0, 32'h500, 32'h0000_007F,
              exc("illegal", 32'h500, 0, EXC_ILLEGAL));
        e = ok("sb", 32'h504, 0, ALU_ADD, 0, 0,
               32'hFFFF_FFFC, 1, 0, 0);
        e.wen = 1'b1; e.mbyte = 1'b1;
        drive(0, 32'h504, enc_s(12'hFFC, 2, 1, 3'b000), e);
        e = ok("jal", 32'h508, 3, ALU_PASS, 0, 0,
               32'h0000_0800, 0, 1, 1);
        e.jmp = 1'b1;
        drive(3, 32'h508, enc_j(21'h800, 1), e);
        e = ok("beq", 32'h50C, 3, ALU_SUB, 0, 0,
               32'hFFFF_FFF8, 0, 0, 0);
        e.br = 1'b1;
        drive(3, 32'h50C, enc_b(13'h1FF8, 0, 0), e);

        bus.flush_en = 1'b1; bus.flush_thread = 1;
        drive(1, 32'h600, enc_i(12'd0, 0, 3'b010, 4, OP_LOAD),
              bub("lw_flushed"));
        e = ok("lw_x9", 32'h604, 1, ALU_ADD, 0, 0, 0, 1, 9, 1);
        e.ren = 1'b1;
        drive(1, 32'h604, enc_i(12'd0, 4, 3'b010, 9, OP_LOAD), e);

        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.valid", 32'(bus.ex_valid), 32'h0);
        chk("midrst.pc", bus.ex_pc, 32'h0);
        chk("midrst.rd", 32'(bus.ex_rd), 32'h0);
        chk("midrst.ren", 32'(bus.ex_mem_ren), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        drive(1, 32'h700, enc_r(F7_ADD, 2, 1, 3),
              ok("post_rst_add", 32'h700, 1, ALU_ADD,
                 0, 0, 0, 0, 3, 1));
        drive(0, 32'h704, enc_r(F7_ADD, 5, 5, 15),
              ok("post_rst_rf", 32'h704, 0, ALU_ADD,
                 0, 0, 0, 0, 15, 1));
        bus.if_icache_miss = 1'b1;
        drive(0, 32'h708, 32'h0, bub("idle"));
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
